// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the key schedule and S-box.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } key_exp_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  aes_byte_t inv;
  aes_byte_t sq;

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required.
  always_comb begin
    inv = 8'h01;
    sq  = in_i;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (word_i[8*b +: 8]),
      .out_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: accepts a cipher key and streams round keys 0..10
// over a valid/ready handshake, one new key per cycle without backpressure.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [127:0] Key_in,
  input  logic         Key_valid,
  output logic         Key_ready,
  output logic [127:0] Round_key,
  output logic [3:0]   Round_key_idx,
  output logic         Round_key_valid,
  input  logic         Round_key_ready
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
    $error("aes_key_expansion: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  key_exp_state_t state_q, state_d;
  aes_block_t     key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  aes_byte_t      rcon_q, rcon_d;
  logic           valid_q, valid_d;
  logic           kready_q, kready_d;

  aes_word_t  w0, w1, w2, w3, rot_w3, sub_w3, t;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t next_key;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  assign t        = sub_w3 ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (Key_valid && kready_q) begin
          key_d   = Key_in;
          idx_d   = '0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (Round_key_ready) begin
          if (idx_q == 4'(NUM_ROUNDS)) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            key_d  = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Key_ready is registered from the next state so it tracks state_q with no input path.
    kready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      idx_q    <= '0;
      rcon_q   <= 8'h01;
      valid_q  <= 1'b0;
      kready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      rcon_q   <= rcon_d;
      valid_q  <= valid_d;
      kready_q <= kready_d;
    end
  end

  assign Key_ready       = kready_q;
  assign Round_key       = key_q;
  assign Round_key_idx   = idx_q;
  assign Round_key_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion against a word-array FIPS-197 key schedule model.
module tb_aes_key_expansion;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [127:0] Key_in = '0;
  logic         Key_valid = 1'b0;
  logic         Key_ready;
  logic [127:0] Round_key;
  logic [3:0]   Round_key_idx;
  logic         Round_key_valid;
  logic         Round_key_ready = 1'b0;

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Key_in          (Key_in),
    .Key_valid       (Key_valid),
    .Key_ready       (Key_ready),
    .Round_key       (Round_key),
    .Round_key_idx   (Round_key_idx),
    .Round_key_valid (Round_key_valid),
    .Round_key_ready (Round_key_ready)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  logic [7:0]   sbox [256];
  logic [127:0] model_rk [11];
  logic [127:0] got_rk [11];
  int           last_cycles;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vec [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  function automatic void build_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = p ^ (p << 1);
      if ((p & 'h100) != 0) p = p ^ 'h11b;
      q = (q ^ (q << 1)) & 'hff;
      q = (q ^ (q << 2)) & 'hff;
      q = (q ^ (q << 4)) & 'hff;
      if ((q & 'h80) != 0) q = q ^ 'h09;
      x = q;
      for (int k = 1; k <= 4; k++) x = x ^ (((q << k) | (q >> (8 - k))) & 'hff);
      sbox[p] = 8'(x ^ 'h63);
    end while (p != 1);
    sbox[0] = 8'h63;
  endfunction

  function automatic void build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox[temp[31:24]], sbox[temp[23:16]], sbox[temp[15:8]], sbox[temp[7:0]]};
        temp = temp ^ {8'(rc), 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic send_key(input logic [127:0] k);
    int w;
    for (w = 0; w < 50 && Key_ready !== 1'b1; w++) @(negedge Clk);
    if (Key_ready !== 1'b1) check("key_ready_timeout", {127'b0, Key_ready}, 128'd1);
    Key_in    = k;
    Key_valid = 1'b1;
    @(negedge Clk);
    Key_valid = 1'b0;
  endtask

  // Consume round keys from the DUT with a given stall percentage, then compare to the model.
  task automatic collect(input int stall_pct, input string tag);
    int got, cyc, stable_err, seq_err;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    bit prev_stall, rdy;
    got = 0; stable_err = 0; seq_err = 0; prev_stall = 0;
    prev_key = '0; prev_idx = '0;
    for (cyc = 0; cyc < 500 && got < 11; cyc++) begin
      if (Round_key_valid !== 1'b1 || Round_key_idx !== 4'(got)) seq_err++;
      if (prev_stall && (Round_key !== prev_key || Round_key_idx !== prev_idx)) stable_err++;
      rdy = ($urandom_range(99) >= stall_pct);
      Round_key_ready = rdy;
      if (rdy) begin
        got_rk[got] = Round_key;
        got++;
      end
      prev_stall = !rdy;
      prev_key   = Round_key;
      prev_idx   = Round_key_idx;
      @(negedge Clk);
    end
    Round_key_ready = 1'b0;
    last_cycles = cyc;
    check({tag, "_count"}, 128'(got), 128'd11);
    check({tag, "_seq_err"}, 128'(seq_err), 128'd0);
    check({tag, "_stable_err"}, 128'(stable_err), 128'd0);
    check({tag, "_done_valid"}, {127'b0, Round_key_valid}, 128'd0);
    check({tag, "_done_key_ready"}, {127'b0, Key_ready}, 128'd1);
    check({tag, "_done_idx"}, {124'b0, Round_key_idx}, 128'd10);
    for (int r = 0; r < 11 && r < got; r++)
      check($sformatf("%s_rk%0d", tag, r), got_rk[r], model_rk[r]);
  endtask

  initial begin
    logic [127:0] k, ka, kb;
    int err, w;

    build_sbox();
    vec[0] = '{"fips_idx0",  128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vec[1] = '{"fips_idx1",  128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vec[2] = '{"fips_idx10", 128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vec[3] = '{"zero_idx1",  128'h0,                                1,  128'h62636363626363636263636362636363};
    vec[4] = '{"zero_idx10", 128'h0,                                10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // Reset values and quiet idle.
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    check("rst_key_ready", {127'b0, Key_ready}, 128'd1);
    check("rst_round_key", Round_key, 128'd0);
    check("rst_idx", {124'b0, Round_key_idx}, 128'd0);
    check("rst_valid", {127'b0, Round_key_valid}, 128'd0);
    err = 0;
    for (int i = 0; i < 4; i++) begin
      if (Round_key_valid !== 1'b0) err++;
      @(negedge Clk);
    end
    check("idle_no_valid", 128'(err), 128'd0);

    // Known-answer vectors, full rate.
    for (int i = 0; i < 5; i++) begin
      build_model(vec[i].key);
      send_key(vec[i].key);
      collect(0, vec[i].name);
      check({vec[i].name, "_kat"}, got_rk[vec[i].idx], vec[i].exp);
      check({vec[i].name, "_consecutive"}, 128'(last_cycles), 128'd11);
    end

    // Random keys, full rate and with random backpressure.
    for (int i = 0; i < 8; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      build_model(k);
      send_key(k);
      collect((i < 4) ? 0 : 40, $sformatf("rand%0d", i));
    end

    // Back-to-back: second key held valid through the whole first expansion.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    for (w = 0; w < 50 && Key_ready !== 1'b1; w++) @(negedge Clk);
    Key_in = ka;
    Key_valid = 1'b1;
    @(negedge Clk);
    Key_in = kb;
    Round_key_ready = 1'b1;
    err = 0;
    for (int c = 1; c <= 11; c++) begin
      if (Key_ready !== 1'b0) err++;
      @(negedge Clk);
    end
    check("b2b_key_ready_low", 128'(err), 128'd0);
    check("b2b_key_ready_n12", {127'b0, Key_ready}, 128'd1);
    Round_key_ready = 1'b0;
    @(negedge Clk);
    Key_valid = 1'b0;
    check("b2b_n13_valid", {127'b0, Round_key_valid}, 128'd1);
    check("b2b_n13_idx", {124'b0, Round_key_idx}, 128'd0);
    check("b2b_n13_key", Round_key, kb);
    check("b2b_n13_key_ready", {127'b0, Key_ready}, 128'd0);
    build_model(kb);
    collect(0, "b2b_second");

    // Reset while idx=5, then a fresh key must restart from idx0 with rcon=01.
    k = {$urandom, $urandom, $urandom, $urandom};
    send_key(k);
    Round_key_ready = 1'b1;
    for (w = 0; w < 30 && Round_key_idx !== 4'd5; w++) @(negedge Clk);
    check("midrst_reached_idx5", {124'b0, Round_key_idx}, 128'd5);
    Round_key_ready = 1'b0;
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check("midrst_valid", {127'b0, Round_key_valid}, 128'd0);
    check("midrst_round_key", Round_key, 128'd0);
    check("midrst_key_ready", {127'b0, Key_ready}, 128'd1);
    err = 0;
    for (int i = 0; i < 3; i++) begin
      if (Round_key_valid !== 1'b0) err++;
      @(negedge Clk);
    end
    check("midrst_no_more_keys", 128'(err), 128'd0);
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build_model(k);
    send_key(k);
    collect(20, "after_rst");
    check("after_rst_kat10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
